// File: rtl/rvh_l1d_plru_array.sv
// rtl/rvh_l1d_plru_array.sv - tree-PLRU state array with a one-deep victim response register
// Victim choice prefers an empty way; otherwise the tree is walked from pre-update state.
module rvh_l1d_plru_array #(
   parameter  int NSET  = 64,
   parameter  int NWAY  = 8,
   localparam int SET_W = $clog2(NSET),
   localparam int WAY_W = $clog2(NWAY),
   localparam int LRU_W = NWAY - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             hit_vld_i,
   input  logic [SET_W-1:0] hit_set_i,
   input  logic [WAY_W-1:0] hit_way_i,
   input  logic             repl_req_vld_i,
   output logic             repl_req_rdy_o,
   input  logic [SET_W-1:0] repl_req_set_i,
   input  logic [NWAY-1:0]  repl_req_valid_mask_i,
   output logic             repl_resp_vld_o,
   input  logic             repl_resp_rdy_i,
   output logic [WAY_W-1:0] repl_resp_way_o,
   output logic [SET_W-1:0] repl_resp_set_o
);

   logic [LRU_W-1:0] plru_q [NSET];
   logic [LRU_W-1:0] plru_d [NSET];
   logic             resp_vld_q;
   logic [WAY_W-1:0] resp_way_q;
   logic [SET_W-1:0] resp_set_q;
   logic [WAY_W-1:0] victim;
   logic             accept;

   // Node n lives at bit n-1; a 1 steers the walk toward the upper child.
   function automatic logic [WAY_W-1:0] tree_walk(input logic [LRU_W-1:0] t);
      int               node;
      logic [WAY_W-1:0] way;
      node = 1;
      way  = '0;
      for (int l = WAY_W - 1; l >= 0; l--) begin
         way[l] = t[node-1];
         node   = 2 * node + (t[node-1] ? 1 : 0);
      end
      return way;
   endfunction

   // Each node on the path is pointed away from the way just used.
   function automatic logic [LRU_W-1:0] tree_touch(input logic [LRU_W-1:0] t,
                                                   input logic [WAY_W-1:0] w);
      int               node;
      logic [LRU_W-1:0] r;
      node = 1;
      r    = t;
      for (int l = WAY_W - 1; l >= 0; l--) begin
         r[node-1] = ~w[l];
         node      = 2 * node + (w[l] ? 1 : 0);
      end
      return r;
   endfunction

   assign repl_req_rdy_o  = ~resp_vld_q | repl_resp_rdy_i;
   assign accept          = repl_req_vld_i & repl_req_rdy_o;
   assign repl_resp_vld_o = resp_vld_q;
   assign repl_resp_way_o = resp_way_q;
   assign repl_resp_set_o = resp_set_q;

   always_comb begin
      victim = tree_walk(plru_q[repl_req_set_i]);
      for (int i = NWAY - 1; i >= 0; i--) begin
         if (!repl_req_valid_mask_i[i]) victim = WAY_W'(i);
      end
   end

   // Hit touch first, victim touch second, so the victim wins on shared nodes.
   always_comb begin
      for (int s = 0; s < NSET; s++) begin
         plru_d[s] = plru_q[s];
         if (flush_i) begin
            plru_d[s] = '0;
         end else begin
            if (hit_vld_i && (hit_set_i == SET_W'(s)))
               plru_d[s] = tree_touch(plru_d[s], hit_way_i);
            if (accept && (repl_req_set_i == SET_W'(s)))
               plru_d[s] = tree_touch(plru_d[s], victim);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < NSET; s++) plru_q[s] <= '0;
      end else begin
         for (int s = 0; s < NSET; s++) plru_q[s] <= plru_d[s];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_vld_q <= 1'b0;
         resp_way_q <= '0;
         resp_set_q <= '0;
      end else if (flush_i) begin
         resp_vld_q <= 1'b0;
      end else if (accept) begin
         resp_vld_q <= 1'b1;
         resp_way_q <= victim;
         resp_set_q <= repl_req_set_i;
      end else if (resp_vld_q && repl_resp_rdy_i) begin
         resp_vld_q <= 1'b0;
      end
   end

endmodule

// File: doc/rvh_l1d_plru_array.md
RVH_L1D_PLRU_ARRAY -- requirements
Module: rvh_l1d_plru_array

Interface
REQ-001 The module SHALL have parameter NSET, default 64, meaning number of cache sets (power of 2, >=2).
REQ-002 The module SHALL have parameter NWAY, default 8, meaning ways per set (power of 2, >=2).
REQ-003 The module SHALL have derived parameters SET_W = $clog2(NSET), WAY_W = $clog2(NWAY) and LRU_W = NWAY-1, meaning tree bits per set.
REQ-004 The module SHALL have port clk, input, width 1, meaning the single clock; all state is on its rising edge.
REQ-005 The module SHALL have port rst, input, width 1, meaning an asynchronous, active-low reset.
REQ-006 The module SHALL have port flush_i, input, width 1, meaning clear the PLRU state of every set.
REQ-007 The module SHALL have port hit_vld_i, input, width 1, meaning a cache hit touch this cycle.
REQ-008 The module SHALL have port hit_set_i, input, width SET_W, meaning the set index of the hit.
REQ-009 The module SHALL have port hit_way_i, input, width WAY_W, meaning the way that hit.
REQ-010 The module SHALL have port repl_req_vld_i, input, width 1, meaning a victim request.
REQ-011 The module SHALL have port repl_req_rdy_o, output, width 1, meaning a victim request can be accepted.
REQ-012 The module SHALL have port repl_req_set_i, input, width SET_W, meaning the set to replace in.
REQ-013 The module SHALL have port repl_req_valid_mask_i, input, width NWAY, meaning the line-valid bits of that set.
REQ-014 The module SHALL have port repl_resp_vld_o, output, width 1, meaning the victim response is valid.
REQ-015 The module SHALL have port repl_resp_rdy_i, input, width 1, meaning the consumer takes the response.
REQ-016 The module SHALL have port repl_resp_way_o, output, width WAY_W, meaning the chosen victim way.
REQ-017 The module SHALL have port repl_resp_set_o, output, width SET_W, meaning the set of the response.

Function
REQ-018 Per set, the module SHALL store LRU_W tree bits; node n is 1-based, its children are 2n and 2n+1, and it is stored at bit n-1.
REQ-019 Walk rule: bit = 0 SHALL mean go to the lower child and bit = 1 the upper child; the WAY_W walk decisions, MSB first, SHALL form the way index.
REQ-020 A touch of way w SHALL set every node on w's path to the inverse of the direction w takes at that node; nodes off the path SHALL be unchanged.
REQ-021 A request SHALL be accepted when repl_req_vld_i and repl_req_rdy_o are both 1.
REQ-022 repl_req_rdy_o SHALL equal !repl_resp_vld_o | repl_resp_rdy_i, combinationally.
REQ-023 On the accept cycle, the victim SHALL be the lowest-index way whose valid-mask bit is 0; if all ways are valid, the victim SHALL be the tree-walk result.
REQ-024 The tree walk SHALL use the stored state before this cycle's updates.
REQ-025 Latency SHALL be 1 cycle: repl_resp_vld_o, way and set are registered at the accept edge and visible the next cycle.
REQ-026 The response SHALL stay stable until the cycle in which repl_resp_vld_o and repl_resp_rdy_i are both 1; it SHALL drop afterwards unless a new request is accepted in that same cycle (back-to-back).
REQ-027 An accepted request SHALL touch the victim way in its set at the accept edge.
REQ-028 A hit SHALL touch hit_way_i in hit_set_i at the same edge.
REQ-029 If a hit and an accept target the same set in the same cycle, the hit touch SHALL apply first and the victim touch SHALL win on shared nodes; the victim still SHALL come from the pre-update state.
REQ-030 flush_i SHALL clear all sets to 0 at the next edge and clear repl_resp_vld_o.
REQ-031 flush_i SHALL take priority over a same-cycle hit or accept; a request accepted during flush SHALL be dropped.
REQ-032 Out-of-range indices cannot occur, because widths are exact.

Reset
REQ-033 While rst = 0, asynchronously, all tree bits, repl_resp_vld_o, repl_resp_way_o and repl_resp_set_o SHALL be 0.
REQ-034 While rst = 0, repl_req_rdy_o SHALL be 1.
REQ-035 An assertion of rst in the middle of an operation SHALL discard any pending response immediately.

Verification (NWAY=8, NSET=64)
REQ-036 After reset, 9 back-to-back requests to set 3 with mask 8'hFF and resp_rdy=1 -> ways 0,4,2,6,1,5,3,7,0, one per cycle, each 1 cycle after accept.
REQ-037 After reset, hit set 5 way 0, then a request to set 5 with mask 8'hFF -> way 4; set 6 untouched -> a request there returns way 0.
REQ-038 Request to set 9 with mask 8'hEF -> way 4, and the next all-valid request to set 9 -> way 0.
REQ-039 Response pending with resp_rdy=0 for 3 cycles -> way/set held stable and req_rdy=0; when resp_rdy=1 with req_vld=1 -> back-to-back accept and the next victim follows the next cycle.
REQ-040 After 4 requests to set 3, flush_i pulse (with a same-cycle request) -> no response; the next request to set 3 -> way 0.
REQ-041 rst asserted while a response is pending -> resp_vld 0 without a clock edge; after release, a request to set 3 -> way 0.
